// File: rtl/angle_arb_pkg.sv
// Shared types and constants for the angle engine request arbiter.
// Optional tag/valid mismatch reporting is enabled with ANGLE_ARB_TAG_CHECK_EN.
package angle_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   // Sized for the largest channel count so the tag type stays fixed.
   localparam int TAG_CHAN_W = 3;

   typedef struct packed {
      logic                  valid;
      logic [TAG_CHAN_W-1:0] chan;
   } tag_t;

   localparam int ENG_LAT_DEF = 6;

   localparam logic signed [15:0] PI_FIX       = 16'sd12868;
   localparam logic signed [15:0] PI_DIV_2_FIX = 16'sd6434;

   function automatic tag_t make_tag(input logic valid, input logic [TAG_CHAN_W-1:0] chan);
      tag_t t;
      t.valid = valid;
      t.chan  = chan;
      return t;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search starting one past the pointer; one-hot grant plus encoded index.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   idx,
   output logic              found
);

   // First requesting channel after the pointer wins, wrapping modulo NUM_CH.
   always_comb begin
      int cand;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 1; off <= NUM_CH; off++) begin
         cand = (int'(ptr) + off) % NUM_CH;
         if (en && !found && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = CH_W'(cand);
            found     = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/angle_req_arbiter.sv
// Shares one fixed-latency angle engine among NUM_CH requesters with channel tagging.
// Define ANGLE_ARB_TAG_CHECK_EN to add sticky err_o / err_chan_o mismatch reporting.
module angle_req_arbiter
   import angle_arb_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = $clog2(NUM_CH),
   parameter int ENG_LAT = ENG_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic                  flush_i,
   input  logic [NUM_CH-1:0]     req_val_i,
   output logic [NUM_CH-1:0]     req_rdy_o,
   input  logic [NUM_CH*8-1:0]   req_real_i,
   input  logic [NUM_CH*8-1:0]   req_imag_i,
   output logic                  eng_val_o,
   output logic [7:0]            eng_real_o,
   output logic [7:0]            eng_imag_o,
   input  logic                  eng_val_i,
   input  logic [15:0]           eng_angle_i,
   output logic                  val_o,
   output logic [15:0]           angle_o,
   output logic [CH_W-1:0]       chan_o,
   output logic                  busy_o,
   output logic                  flush_done_o
`ifdef ANGLE_ARB_TAG_CHECK_EN
   ,
   output logic                  err_o,
   output logic [CH_W-1:0]       err_chan_o
`endif
);

   arb_state_e          state_r;
   logic [CH_W-1:0]     ptr_r;
   logic                flush_done_r;
   logic                eng_val_r;
   logic [7:0]          eng_real_r;
   logic [7:0]          eng_imag_r;
   tag_t                tag_r [0:ENG_LAT];
   logic                val_r;
   logic [15:0]         angle_r;
   logic [CH_W-1:0]     chan_r;

   logic                issue_s;
   logic [NUM_CH-1:0]   gnt_s;
   logic [CH_W-1:0]     idx_s;
   logic                xfer_s;
   logic                tags_busy_s;
   logic                hit_s;

   assign issue_s = (state_r == ISSUE);

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr (
      .req   (req_val_i),
      .ptr   (ptr_r),
      .en    (issue_s),
      .gnt   (gnt_s),
      .idx   (idx_s),
      .found (xfer_s)
   );

   // Any valid tag anywhere in the pipe means a result is still owed.
   always_comb begin
      tags_busy_s = 1'b0;
      for (int i = 0; i <= ENG_LAT; i++) begin
         tags_busy_s = tags_busy_s | tag_r[i].valid;
      end
   end

   assign hit_s = eng_val_i & tag_r[ENG_LAT].valid;

   // Enable/flush state machine with the drain-complete pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         flush_done_r <= 1'b0;
      end else begin
         flush_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (en_i) state_r <= ISSUE;
               else      state_r <= IDLE;
            end
            ISSUE: begin
               if (flush_i || !en_i) state_r <= DRAIN;
               else                  state_r <= ISSUE;
            end
            DRAIN: begin
               if (!tags_busy_s && !eng_val_r) begin
                  flush_done_r <= 1'b1;
                  state_r      <= IDLE;
               end else begin
                  state_r <= DRAIN;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Pointer tracks the last served channel so it gets lowest priority next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= CH_W'(NUM_CH - 1);
      end else if (xfer_s) begin
         ptr_r <= idx_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Engine issue register; sample data holds between issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_val_r  <= 1'b0;
         eng_real_r <= 8'd0;
         eng_imag_r <= 8'd0;
      end else begin
         eng_val_r <= xfer_s;
         if (xfer_s) begin
            eng_real_r <= req_real_i[8*int'(idx_s) +: 8];
            eng_imag_r <= req_imag_i[8*int'(idx_s) +: 8];
         end else begin
            eng_real_r <= eng_real_r;
            eng_imag_r <= eng_imag_r;
         end
      end
   end

   // Channel tag pipe; stage ENG_LAT lines up with the engine's output valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= ENG_LAT; i++) begin
            tag_r[i] <= make_tag(1'b0, {TAG_CHAN_W{1'b0}});
         end
      end else begin
         tag_r[0] <= make_tag(xfer_s, TAG_CHAN_W'(idx_s));
         for (int i = 1; i <= ENG_LAT; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   // Result register; untagged engine outputs are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_r   <= 1'b0;
         angle_r <= 16'd0;
         chan_r  <= '0;
      end else begin
         val_r <= hit_s;
         if (hit_s) begin
            angle_r <= eng_angle_i;
            chan_r  <= tag_r[ENG_LAT].chan[CH_W-1:0];
         end else begin
            angle_r <= 16'd0;
            chan_r  <= chan_r;
         end
      end
   end

`ifdef ANGLE_ARB_TAG_CHECK_EN
   logic            err_r;
   logic [CH_W-1:0] err_chan_r;

   // Sticky record of the first tag/valid disagreement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r      <= 1'b0;
         err_chan_r <= '0;
      end else if ((eng_val_i ^ tag_r[ENG_LAT].valid) && !err_r) begin
         err_r      <= 1'b1;
         err_chan_r <= tag_r[ENG_LAT].chan[CH_W-1:0];
      end else begin
         err_r      <= err_r;
         err_chan_r <= err_chan_r;
      end
   end

   assign err_o      = err_r;
   assign err_chan_o = err_chan_r;
`endif

   assign req_rdy_o    = gnt_s;
   assign eng_val_o    = eng_val_r;
   assign eng_real_o   = eng_real_r;
   assign eng_imag_o   = eng_imag_r;
   assign val_o        = val_r;
   assign angle_o      = angle_r;
   assign chan_o       = chan_r;
   assign busy_o       = (state_r != IDLE) | tags_busy_s;
   assign flush_done_o = flush_done_r;

endmodule

// File: doc/angle_req_arbiter.md
Name: angle_req_arbiter

Overview:
- Shares one angle engine (8-bit I/Q in, 16-bit signed fixed-point angle out, fixed latency, no backpressure) among NUM_CH requesters.
- Round-robin grant, at most one issue per cycle.
- Tags each issue with its channel ID through a shift register matched to the engine latency, and returns the angle with the channel ID.
- Enable/flush FSM for clean stop and drain.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- CH_W, 2, channel ID width, equal to clog2(NUM_CH).
- ENG_LAT, 6, cycles from eng_val_o high to the matching eng_val_i high. Must equal the engine's real latency.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  level; allow issuing
- flush_i  in  1  pulse; stop issuing and drain
- req_val_i  in  NUM_CH  per-channel request valid
- req_rdy_o  out  NUM_CH  per-channel ready (one-hot or zero)
- req_real_i  in  NUM_CH*8  packed; channel k at [8k+7:8k]
- req_imag_i  in  NUM_CH*8  packed, same layout
- eng_val_o  out  1  engine input valid
- eng_real_o  out  8  engine real sample
- eng_imag_o  out  8  engine imag sample
- eng_val_i  in  1  engine output valid
- eng_angle_i  in  16  engine angle
- val_o  out  1  result valid
- angle_o  out  16  result angle
- chan_o  out  CH_W  result channel
- busy_o  out  1  high when state is not IDLE or any tag is in flight
- flush_done_o  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset: all outputs 0; FSM in IDLE; RR pointer = NUM_CH-1, so channel 0 has first priority; tag pipe cleared.
- FSM states:
  - IDLE: go to ISSUE when en_i=1.
  - ISSUE: go to DRAIN when flush_i=1 or en_i=0.
  - DRAIN: no grants. When the tag pipe is empty and eng_val_o=0, pulse flush_done_o and go to IDLE.
- flush_i in IDLE: ignored, no pulse. flush_i in DRAIN: ignored.
- Grant:
  - Combinational, only in ISSUE.
  - Search req_val_i starting at pointer+1, wrapping modulo NUM_CH. The first set bit gets req_rdy_o.
  - req_val_i must not depend on req_rdy_o.
  - Transfer = val & rdy on the granted channel.
- Pointer update: on a transfer, pointer <= granted channel; otherwise it holds.
- If the transition to DRAIN occurs in the same cycle as a grant, the grant is still honoured. rdy was already visible, so the transfer completes.
- Issue: a transfer in cycle t registers eng_val_o=1 and eng_real_o/eng_imag_o = the granted channel's data in cycle t+1. Data holds its value when not valid.
- Tag pipe:
  - ENG_LAT+1 stages of {valid, chan}, loaded together with eng_val_o.
  - The tail stage aligns with eng_val_i.
- Return:
  - When eng_val_i=1, register val_o=1, angle_o=eng_angle_i, chan_o=tail tag chan.
  - Total latency from transfer to val_o: ENG_LAT+2 cycles.
  - When val_o=0, angle_o is driven 0 and chan_o holds its last value.
- Mismatches:
  - eng_val_i=1 with an invalid tail tag: result dropped (val_o=0).
  - Valid tail tag with eng_val_i=0: tag discarded.
- Throughput: one result per cycle sustained. Every requester is served within NUM_CH cycles while it holds val.
- Reset mid-operation: the tag pipe is cleared and in-flight results are dropped. The engine must share rst_n or be idle ENG_LAT cycles before release.

Optional Feature:
- Macro: ANGLE_ARB_TAG_CHECK_EN.
- When defined:
  - Adds output err_o (1 bit, reset 0), sticky until rst_n.
  - Set on either tag/valid mismatch.
  - Adds output err_chan_o (CH_W), capturing the tail tag chan of the first mismatch.
- When undefined: ports absent; mismatches are silently handled as in Behaviour.

Decomposition:
- Package angle_arb_pkg holds:
  - FSM state enum: IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2.
  - Tag struct {valid, chan}.
  - Default ENG_LAT constant.
  - Angle fixed-point constants: PI_FIX=12868, PI_DIV_2_FIX=6434.
- Sub-module rr_arbiter (NUM_CH): req vector, pointer, enable in; one-hot grant and encoded index out.
- Tag shift register stays inline.

Test Plan:
- Single channel: en_i=1, ch2 issues real=8'd100, imag=8'd0 at t. Expect eng_val_o at t+1, and val_o at t+ENG_LAT+2 with chan_o=2 and angle_o as supplied by the engine model.
- All 4 channels hold val continuously for 12 cycles. Grants go 0,1,2,3,0,1,2,3,..., 12 transfers total, and chan_o follows the same order ENG_LAT+2 cycles later.
- Channels 1 and 3 only. Grants alternate 1,3,1,3; the pointer skips idle channels; no grant ever goes to 0 or 2.
- flush_i pulse during a 4-channel burst. No rdy from the next cycle. The last val_o comes ENG_LAT+2 after the final transfer. flush_done_o pulses exactly once, then FSM is IDLE and busy_o=0.
- rst_n asserted mid-burst with 3 tags in flight. All outputs are 0 asynchronously. After release no stale val_o appears, and the first grant goes to ch0.
- With ANGLE_ARB_TAG_CHECK_EN: the engine model is configured one cycle slower than ENG_LAT. err_o rises on the first mismatch, err_chan_o = first issued chan, and err_o stays high until reset.
